// File: rtl/conv2d_3x3_pkg.sv
// Shared constants and the round/saturate helper for the conv2d_3x3 tap multiplier.
package conv2d_3x3_pkg;

  localparam int MAX_NUM_STAGE = 4;
  // Working width for rounding; every instance's operand-extended product must fit.
  localparam int MAX_PROD_W    = 64;

  typedef logic signed [MAX_PROD_W-1:0] wide_t;

  typedef struct packed {
    logic [MAX_PROD_W-1:0] value;
    logic                  sat;
  } round_sat_t;

  function automatic int prod_width(input int w0, input int w1);
    return w0 + w1 + 1;
  endfunction

  // Round half toward +inf, then clip to the signed or unsigned result range when enabled.
  function automatic round_sat_t round_sat(input wide_t product, input int shift,
                                           input int width, input logic rs,
                                           input logic sat_en);
    wide_t      rounded;
    wide_t      hi;
    wide_t      lo;
    round_sat_t res;
    rounded = product;
    if (shift > 0) rounded = (product + (wide_t'(1) <<< (shift - 1))) >>> shift;
    if (rs) begin
      hi = (wide_t'(1) <<< (width - 1)) - wide_t'(1);
      lo = -(wide_t'(1) <<< (width - 1));
    end else begin
      hi = (wide_t'(1) <<< width) - wide_t'(1);
      lo = '0;
    end
    res.value = rounded;
    res.sat   = 1'b0;
    if (sat_en) begin
      if (rounded > hi) begin
        res.value = hi;
        res.sat   = 1'b1;
      end else if (rounded < lo) begin
        res.value = lo;
        res.sat   = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/conv2d_3x3_pipe_ctrl.sv
// Valid-bit shift register and global stall enable for the tap multiplier pipeline.
module conv2d_3x3_pipe_ctrl
  import conv2d_3x3_pkg::*;
#(
  parameter int NUM_STAGE = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_in_valid,
  input  logic i_out_ready,
  output logic o_in_ready,
  output logic o_out_valid,
  output logic o_en
);

  logic [NUM_STAGE-1:0] r_stage_vld;
  logic                 w_en;

  // The whole pipe moves as one; an empty output slot never blocks it.
  assign w_en        = ~r_stage_vld[NUM_STAGE-1] | i_out_ready;
  assign o_en        = w_en;
  assign o_in_ready  = w_en;
  assign o_out_valid = r_stage_vld[NUM_STAGE-1];

  // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stage_vld <= '0;
    end else if (w_en) begin
      r_stage_vld <= NUM_STAGE'({r_stage_vld, i_in_valid});
    end
  end

endmodule

// File: rtl/conv2d_3x3_mul_pipe.sv
// Pipelined fixed-point tap multiplier: extend, multiply, round, saturate, with full-pipe stall.
module conv2d_3x3_mul_pipe
  import conv2d_3x3_pkg::*;
#(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 2,
  parameter int din0_WIDTH = 14,
  parameter int din1_WIDTH = 12,
  parameter int dout_WIDTH = 16,
  parameter int SIGNED0    = 0,
  parameter int SIGNED1    = 0,
  parameter int SHIFT      = 8,
  parameter int SAT        = 1
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  sat
);

  localparam int   DEPTH  = (NUM_STAGE < 1) ? 1 :
                            (NUM_STAGE > MAX_NUM_STAGE) ? MAX_NUM_STAGE : NUM_STAGE;
  localparam int   P      = prod_width(din0_WIDTH, din1_WIDTH);
  localparam logic RS     = (SIGNED0 != 0) || (SIGNED1 != 0);
  localparam logic SAT_EN = (SAT != 0);

  typedef logic signed [P-1:0] prod_t;

  function automatic prod_t ext0(input logic [din0_WIDTH-1:0] x);
    if (SIGNED0 != 0) return prod_t'(signed'(x));
    return prod_t'(x);
  endfunction

  function automatic prod_t ext1(input logic [din1_WIDTH-1:0] x);
    if (SIGNED1 != 0) return prod_t'(signed'(x));
    return prod_t'(x);
  endfunction

  logic w_en;

  conv2d_3x3_pipe_ctrl #(
    .NUM_STAGE (DEPTH)
  ) u_ctrl (
    .i_clk       (ap_clk),
    .i_rst       (ap_rst),
    .i_in_valid  (in_valid),
    .i_out_ready (out_ready),
    .o_in_ready  (in_ready),
    .o_out_valid (out_valid),
    .o_en        (w_en)
  );

  prod_t w_op0;
  prod_t w_op1;
  prod_t w_mul;
  prod_t w_last;

  generate
    if (DEPTH == 1) begin : g_comb_ops
      assign w_op0 = ext0(din0);
      assign w_op1 = ext1(din1);
    end else begin : g_reg_ops
      logic [din0_WIDTH-1:0] r_din0;
      logic [din1_WIDTH-1:0] r_din1;
      // NOTE: data registers are not reset; the valid bits alone decide what is real.
      always_ff @(posedge ap_clk) begin
        if (w_en) begin
          r_din0 <= din0;
          r_din1 <= din1;
        end
      end
      assign w_op0 = ext0(r_din0);
      assign w_op1 = ext1(r_din1);
    end
  endgenerate

  // P bits hold the exact product for any signedness mix.
  assign w_mul = w_op0 * w_op1;

  generate
    if (DEPTH >= 3) begin : g_mul_pipe
      prod_t r_prod [DEPTH-2];
      always_ff @(posedge ap_clk) begin
        if (w_en) begin
          r_prod[0] <= w_mul;
          for (int i = 1; i < DEPTH - 2; i++) r_prod[i] <= r_prod[i-1];
        end
      end
      assign w_last = r_prod[DEPTH-3];
    end else begin : g_mul_direct
      assign w_last = w_mul;
    end
  endgenerate

  round_sat_t            w_rs;
  logic [dout_WIDTH-1:0] r_dout;
  logic                  r_sat;
  logic                  w_unused;

  assign w_rs = round_sat(wide_t'(w_last), SHIFT, dout_WIDTH, RS, SAT_EN);

  always_ff @(posedge ap_clk) begin
    if (w_en) begin
      r_dout <= w_rs.value[dout_WIDTH-1:0];
      r_sat  <= w_rs.sat;
    end
  end

  // Stale data never leaks out: outputs read as zero whenever no result is presented.
  assign dout = out_valid ? r_dout : '0;
  assign sat  = out_valid & r_sat;

  assign w_unused = ^{w_rs.value[MAX_PROD_W-1:dout_WIDTH], ID[0]};

endmodule

// File: tb/tb_conv2d_3x3_mul_pipe.sv
// Directed bench for conv2d_3x3_mul_pipe: four configurations share one stimulus bus.
module tb_conv2d_3x3_mul_pipe;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        in_valid;
  logic        out_ready;
  logic [13:0] din0;
  logic [11:0] din1;

  logic        def_in_ready, def_ov, def_sat;
  logic [15:0] def_dout;
  logic        nos_in_ready, nos_ov, nos_sat;
  logic [15:0] nos_dout;
  logic        sgn_in_ready, sgn_ov, sgn_sat;
  logic [15:0] sgn_dout;
  logic        ns3_in_ready, ns3_ov, ns3_sat;
  logic [15:0] ns3_dout;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 ap_clk = ~ap_clk;

  conv2d_3x3_mul_pipe u_def (
    .ap_clk (ap_clk), .ap_rst (ap_rst), .in_valid (in_valid), .in_ready (def_in_ready),
    .din0 (din0), .din1 (din1), .out_valid (def_ov), .out_ready (out_ready),
    .dout (def_dout), .sat (def_sat)
  );

  conv2d_3x3_mul_pipe #(.SAT(0)) u_nosat (
    .ap_clk (ap_clk), .ap_rst (ap_rst), .in_valid (in_valid), .in_ready (nos_in_ready),
    .din0 (din0), .din1 (din1), .out_valid (nos_ov), .out_ready (out_ready),
    .dout (nos_dout), .sat (nos_sat)
  );

  conv2d_3x3_mul_pipe #(.SIGNED0(1)) u_sgn (
    .ap_clk (ap_clk), .ap_rst (ap_rst), .in_valid (in_valid), .in_ready (sgn_in_ready),
    .din0 (din0), .din1 (din1), .out_valid (sgn_ov), .out_ready (out_ready),
    .dout (sgn_dout), .sat (sgn_sat)
  );

  conv2d_3x3_mul_pipe #(.NUM_STAGE(3)) u_ns3 (
    .ap_clk (ap_clk), .ap_rst (ap_rst), .in_valid (in_valid), .in_ready (ns3_in_ready),
    .din0 (din0), .din1 (din1), .out_valid (ns3_ov), .out_ready (out_ready),
    .dout (ns3_dout), .sat (ns3_sat)
  );

  task automatic step();
    @(negedge ap_clk);
  endtask

  task automatic idle(input int n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (n) step();
  endtask

  // Offers one beat and returns when a two-stage instance presents it.
  task automatic beat(input logic [13:0] d0, input logic [11:0] d1);
    din0 = d0; din1 = d1; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_reset();
    ap_rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; din0 = '0; din1 = '0;
    step(); step();
    ap_rst = 1'b0;
    #1;
    n_tests++; if (def_ov !== 1'b0) begin n_fail++; $display("FAIL reset_def_ov: got %b want 0", def_ov); end
    n_tests++; if (def_dout !== 16'd0) begin n_fail++; $display("FAIL reset_def_dout: got %0d want 0", def_dout); end
    n_tests++; if (def_sat !== 1'b0) begin n_fail++; $display("FAIL reset_def_sat: got %b want 0", def_sat); end
    n_tests++; if (def_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_def_in_ready: got %b want 1", def_in_ready); end
    n_tests++; if (ns3_ov !== 1'b0) begin n_fail++; $display("FAIL reset_ns3_ov: got %b want 0", ns3_ov); end
    n_tests++; if (ns3_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ns3_in_ready: got %b want 1", ns3_in_ready); end
    idle(2);
  endtask

  task automatic test_unsigned();
    // 1000*200 = 200000; (200000+128)>>8 = 781
    din0 = 14'd1000; din1 = 12'd200; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    n_tests++; if (def_ov !== 1'b0) begin n_fail++; $display("FAIL lat_def_early: got %b want 0", def_ov); end
    step();
    n_tests++; if (def_ov !== 1'b1) begin n_fail++; $display("FAIL lat_def_ov: got %b want 1", def_ov); end
    n_tests++; if (def_dout !== 16'd781) begin n_fail++; $display("FAIL u1000x200_dout: got %0d want 781", def_dout); end
    n_tests++; if (def_sat !== 1'b0) begin n_fail++; $display("FAIL u1000x200_sat: got %b want 0", def_sat); end
    n_tests++; if (sgn_dout !== 16'd781) begin n_fail++; $display("FAIL s1000x200_dout: got %0d want 781", sgn_dout); end
    n_tests++; if (ns3_ov !== 1'b0) begin n_fail++; $display("FAIL lat_ns3_early: got %b want 0", ns3_ov); end
    step();
    n_tests++; if (def_ov !== 1'b0) begin n_fail++; $display("FAIL lat_def_after: got %b want 0", def_ov); end
    n_tests++; if (def_dout !== 16'd0) begin n_fail++; $display("FAIL idle_dout_zero: got %0d want 0", def_dout); end
    n_tests++; if (ns3_ov !== 1'b1) begin n_fail++; $display("FAIL lat_ns3_ov: got %b want 1", ns3_ov); end
    n_tests++; if (ns3_dout !== 16'd781) begin n_fail++; $display("FAIL ns3_dout: got %0d want 781", ns3_dout); end
    idle(3);
    // 3*128 = 384 = 1.5*256, tie rounds up to 2
    beat(14'd3, 12'd128);
    n_tests++; if (def_dout !== 16'd2) begin n_fail++; $display("FAIL u_tie_dout: got %0d want 2", def_dout); end
    idle(3);
  endtask

  task automatic test_unsigned_sat();
    // 16383*4095 = 67088385 -> 262064 after rounding
    beat(14'd16383, 12'd4095);
    n_tests++; if (def_dout !== 16'hFFFF) begin n_fail++; $display("FAIL usat_dout: got %0h want ffff", def_dout); end
    n_tests++; if (def_sat !== 1'b1) begin n_fail++; $display("FAIL usat_sat: got %b want 1", def_sat); end
    n_tests++; if (nos_dout !== 16'hFFB0) begin n_fail++; $display("FAIL utrunc_dout: got %0h want ffb0", nos_dout); end
    n_tests++; if (nos_sat !== 1'b0) begin n_fail++; $display("FAIL utrunc_sat: got %b want 0", nos_sat); end
    // Signed view: -1*4095 = -4095; (-4095+128)>>>8 = -16
    n_tests++; if (sgn_dout !== 16'hFFF0) begin n_fail++; $display("FAIL sneg4095_dout: got %0h want fff0", sgn_dout); end
    n_tests++; if (sgn_sat !== 1'b0) begin n_fail++; $display("FAIL sneg4095_sat: got %b want 0", sgn_sat); end
    idle(3);
  endtask

  task automatic test_signed();
    beat(14'h3FFF, 12'd256);
    n_tests++; if (sgn_dout !== 16'hFFFF) begin n_fail++; $display("FAIL sm1_dout: got %0h want ffff", sgn_dout); end
    n_tests++; if (sgn_sat !== 1'b0) begin n_fail++; $display("FAIL sm1_sat: got %b want 0", sgn_sat); end
    n_tests++; if (def_dout !== 16'd16383) begin n_fail++; $display("FAIL u16383x256_dout: got %0d want 16383", def_dout); end
    idle(3);
    // -8192*4095 -> -131040, below -32768
    beat(14'h2000, 12'd4095);
    n_tests++; if (sgn_dout !== 16'h8000) begin n_fail++; $display("FAIL smin_dout: got %0h want 8000", sgn_dout); end
    n_tests++; if (sgn_sat !== 1'b1) begin n_fail++; $display("FAIL smin_sat: got %b want 1", sgn_sat); end
    n_tests++; if (nos_dout !== 16'hFFE0) begin n_fail++; $display("FAIL u8192_trunc: got %0h want ffe0", nos_dout); end
    idle(3);
    // 8191*4095 -> 131024, above 32767
    beat(14'h1FFF, 12'd4095);
    n_tests++; if (sgn_dout !== 16'h7FFF) begin n_fail++; $display("FAIL smax_dout: got %0h want 7fff", sgn_dout); end
    n_tests++; if (sgn_sat !== 1'b1) begin n_fail++; $display("FAIL smax_sat: got %b want 1", sgn_sat); end
    idle(3);
    // -1*128 = -0.5 after shift: tie rounds toward +inf, to 0
    beat(14'h3FFF, 12'd128);
    n_tests++; if (sgn_dout !== 16'd0) begin n_fail++; $display("FAIL sneg_tie_dout: got %0h want 0", sgn_dout); end
    idle(3);
  endtask

  task automatic test_back_to_back();
    logic        exp_v;
    logic [15:0] exp_d;
    for (int c = 0; c < 8; c++) begin
      exp_v = (c >= 2) && (c - 2 < 5);
      exp_d = exp_v ? 16'(100 * (c - 2) + 5) : 16'd0;
      n_tests++; if (def_ov !== exp_v) begin n_fail++; $display("FAIL b2b_ov c=%0d: got %b want %b", c, def_ov, exp_v); end
      n_tests++; if (def_dout !== exp_d) begin n_fail++; $display("FAIL b2b_dout c=%0d: got %0d want %0d", c, def_dout, exp_d); end
      out_ready = 1'b1;
      in_valid  = (c < 5);
      din0      = 14'(100 * c + 5);
      din1      = 12'd256;
      step();
    end
    idle(3);
  endtask

  task automatic test_bubbles();
    logic        exp_v;
    logic [15:0] exp_d;
    for (int c = 0; c < 11; c++) begin
      exp_v = (c >= 2) && ((c - 2) % 2 == 0) && (c - 2 < 8);
      exp_d = exp_v ? 16'(c - 2 + 11) : 16'd0;
      n_tests++; if (def_ov !== exp_v) begin n_fail++; $display("FAIL bub_ov c=%0d: got %b want %b", c, def_ov, exp_v); end
      n_tests++; if (def_dout !== exp_d) begin n_fail++; $display("FAIL bub_dout c=%0d: got %0d want %0d", c, def_dout, exp_d); end
      out_ready = 1'b1;
      in_valid  = (c < 8) && (c % 2 == 0);
      din0      = 14'(c + 11);
      din1      = 12'd256;
      #1;
      n_tests++; if (def_in_ready !== 1'b1) begin n_fail++; $display("FAIL bub_in_ready c=%0d: got %b want 1", c, def_in_ready); end
      step();
    end
    idle(3);
  endtask

  task automatic test_backpressure();
    int   sent = 0;
    int   got  = 0;
    logic acc;
    for (int c = 0; c < 60 && got < 10; c++) begin
      out_ready = !(c >= 4 && c <= 9);
      in_valid  = (sent < 10);
      din0      = 14'(sent);
      din1      = 12'd256;
      #1;
      if (c == 2) begin
        n_tests++; if (ns3_ov !== 1'b0) begin n_fail++; $display("FAIL bp_early_ov: got %b want 0", ns3_ov); end
      end
      if (c == 3) begin
        n_tests++; if (ns3_ov !== 1'b1) begin n_fail++; $display("FAIL bp_first_ov: got %b want 1", ns3_ov); end
        n_tests++; if (ns3_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_c3: got %b want 1", ns3_in_ready); end
      end
      if (c == 4) begin
        n_tests++; if (ns3_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_c4: got %b want 0", ns3_in_ready); end
      end
      if (c >= 4 && c <= 9) begin
        n_tests++; if (ns3_ov !== 1'b1) begin n_fail++; $display("FAIL bp_hold_ov c=%0d: got %b want 1", c, ns3_ov); end
        n_tests++; if (ns3_dout !== 16'd1) begin n_fail++; $display("FAIL bp_hold_dout c=%0d: got %0d want 1", c, ns3_dout); end
      end
      if (ns3_ov && out_ready) begin
        n_tests++; if (ns3_dout !== 16'(got)) begin n_fail++; $display("FAIL bp_order: got %0d want %0d", ns3_dout, got); end
        got++;
      end
      acc = in_valid && ns3_in_ready;
      step();
      if (acc) sent++;
    end
    n_tests++; if (got != 10) begin n_fail++; $display("FAIL bp_count: got %0d results want 10", got); end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      n_tests++; if (ns3_ov !== 1'b0) begin n_fail++; $display("FAIL bp_dup c=%0d: got ov %b want 0", c, ns3_ov); end
      step();
    end
  endtask

  task automatic test_reset_midstream();
    logic stale = 1'b0;
    for (int c = 0; c < 3; c++) begin
      din0 = 14'(20 + c); din1 = 12'd256; in_valid = 1'b1; out_ready = 1'b1;
      step();
    end
    n_tests++; if (ns3_ov !== 1'b1) begin n_fail++; $display("FAIL mid_full_ov: got %b want 1", ns3_ov); end
    in_valid = 1'b0; out_ready = 1'b0; ap_rst = 1'b1;
    step();
    ap_rst = 1'b0;
    #1;
    n_tests++; if (ns3_ov !== 1'b0) begin n_fail++; $display("FAIL mid_ov: got %b want 0", ns3_ov); end
    n_tests++; if (ns3_dout !== 16'd0) begin n_fail++; $display("FAIL mid_dout: got %0d want 0", ns3_dout); end
    n_tests++; if (ns3_sat !== 1'b0) begin n_fail++; $display("FAIL mid_sat: got %b want 0", ns3_sat); end
    n_tests++; if (ns3_in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready: got %b want 1", ns3_in_ready); end
    for (int c = 0; c < 8; c++) begin
      if (ns3_ov || def_ov) stale = 1'b1;
      step();
    end
    n_tests++; if (stale !== 1'b0) begin n_fail++; $display("FAIL mid_stale: got %b want 0", stale); end
    idle(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_unsigned();
    test_unsigned_sat();
    test_signed();
    test_back_to_back();
    test_bubbles();
    test_backpressure();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
